// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into instruction memory, launches the core and times its run.
// Optional run timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int D  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          imem_we,
    output logic [D-1:0]  imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic [CW-1:0] cycles,
    output logic [1:0]    err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] CYC_MAX = '1;

    state_t        r_state;
    state_t        w_next;
    logic [D:0]    r_count;
    logic [CW-1:0] r_cycles;
    logic [1:0]    r_err;
    logic          r_we;
    logic [D-1:0]  r_addr;
    logic [W-1:0]  r_wdata;

    logic          w_fresh;
    logic          w_ready;
    logic          w_accept;
    logic [D-1:0]  w_addr_now;
    logic          w_top;
    logic          w_timeout;

    // A word accepted from IDLE/DONE starts a new program at address 0.
    assign w_fresh    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ready    = w_fresh || ((r_state == S_LOAD) && !r_count[D]);
    assign w_accept   = in_valid && w_ready;
    assign w_addr_now = (r_state == S_LOAD) ? r_count[D-1:0] : '0;
    assign w_top      = &w_addr_now;

`ifdef PROG_LOADER_TIMEOUT_EN
    assign w_timeout = (r_cycles == CYC_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        core_reset = 1'b0;
        core_req   = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                core_reset = (r_state == S_IDLE);
                finished   = (r_state == S_DONE);
                if (w_accept) begin
                    w_next = (in_last || w_top) ? S_LAUNCH : S_LOAD;
                end
            end
            S_LOAD: begin
                core_reset = 1'b1;
                busy       = 1'b1;
                if (w_accept && (in_last || w_top)) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_req = 1'b1;
                busy     = 1'b1;
                w_next   = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (core_done || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_cycles <= '0;
            r_err    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr  <= w_addr_now;
                r_wdata <= in_data;
                if (w_fresh) begin
                    r_count  <= (D+1)'(1);
                    r_cycles <= '0;
                    r_err    <= {1'b0, w_top && !in_last};
                end else begin
                    r_count <= r_count + 1'b1;
                    if (w_top && !in_last) begin
                        r_err[0] <= 1'b1;
                    end
                end
            end
            // core_done ends the run without counting its own cycle.
            if ((r_state == S_RUN) && !core_done) begin
                if (r_cycles != CYC_MAX) begin
                    r_cycles <= r_cycles + 1'b1;
                end
                if (w_timeout) begin
                    r_err[1] <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cycles     = r_cycles;
    assign err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader (D=3, CW=4).
module tb_prog_loader;

    localparam int D  = 3;
    localparam int W  = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [D-1:0]  imem_addr;
    logic [W-1:0]  imem_wdata;
    logic          core_reset;
    logic          core_req;
    logic          core_done = 1'b0;
    logic          busy;
    logic          finished;
    logic [CW-1:0] cycles;
    logic [1:0]    err;

    int n_checks = 0;
    int n_errors = 0;

    prog_loader #(.D(D), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
        .busy(busy), .finished(finished), .cycles(cycles), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({in_ready, core_reset, imem_we, core_req, busy, finished} !== 6'b110000) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 110000", {in_ready, core_reset, imem_we, core_req, busy, finished});
        end
        n_checks++;
        if ({cycles, err, imem_addr, imem_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_values got cyc=%0d err=%b addr=%0d data=%h want all 0", cycles, err, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_load_run();
        logic [W-1:0] words [3];
        words[0] = 9'h1C8; words[1] = 9'h041; words[2] = 9'h0FF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            in_last  = (i == 2);
            step();
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 3'(i), words[i]}) begin
                n_errors++;
                $display("FAIL load_write%0d got we=%b addr=%0d data=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wdata, i, words[i]);
            end
            n_checks++;
            if ({core_req, core_reset} !== ((i == 2) ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL load_core%0d got req/rst=%b want %b", i, {core_req, core_reset}, (i == 2) ? 2'b10 : 2'b01);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        n_checks++;
        if ({imem_we, core_req, busy, cycles} !== {3'b001, 4'd0}) begin
            n_errors++;
            $display("FAIL run_entry got we=%b req=%b busy=%b cyc=%0d want 0 0 1 0", imem_we, core_req, busy, cycles);
        end
        repeat (5) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        n_checks++;
        if ({finished, busy, err, cycles} !== {2'b10, 2'b00, 4'd5}) begin
            n_errors++;
            $display("FAIL run_done got fin=%b busy=%b err=%b cyc=%0d want 1 0 00 5", finished, busy, err, cycles);
        end
        step();
        n_checks++;
        if ({finished, cycles, in_ready, core_reset} !== {1'b1, 4'd5, 2'b10}) begin
            n_errors++;
            $display("FAIL done_hold got fin=%b cyc=%0d rdy=%b crst=%b want 1 5 1 0", finished, cycles, in_ready, core_reset);
        end
    endtask

    task automatic test_gaps();
        logic [5:0] pat;
        logic [W-1:0] words [3];
        int k;
        pat = 6'b101001;
        words[0] = 9'h0AA; words[1] = 9'h155; words[2] = 9'h0C3;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_data  = pat[i] ? words[k] : 9'h1FF;
            in_last  = pat[i] && (k == 2);
            step();
            n_checks++;
            if (pat[i]) begin
                if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 3'(k), words[k]}) begin
                    n_errors++;
                    $display("FAIL gap_write%0d got we=%b addr=%0d data=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wdata, k, words[k]);
                end
                k++;
            end else if (imem_we !== 1'b0) begin
                n_errors++;
                $display("FAIL gap_idle%0d got we=%b want 0", i, imem_we);
            end
            if (i == 0) begin
                n_checks++;
                if ({cycles, err} !== 6'd0) begin
                    n_errors++;
                    $display("FAIL gap_clear got cyc=%0d err=%b want 0 00", cycles, err);
                end
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        core_done = 1'b1;
        step();
        n_checks++;
        if ({busy, finished, core_req} !== 3'b100) begin
            n_errors++;
            $display("FAIL launch_ignores_done got busy=%b fin=%b req=%b want 1 0 0", busy, finished, core_req);
        end
        step();
        core_done = 1'b0;
        n_checks++;
        if ({finished, cycles} !== {1'b1, 4'd0}) begin
            n_errors++;
            $display("FAIL immediate_done got fin=%b cyc=%0d want 1 0", finished, cycles);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 9'h100 + 9'(i);
            in_last  = 1'b0;
            step();
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 3'(i), 9'h100 + 9'(i)}) begin
                n_errors++;
                $display("FAIL ovf_write%0d got we=%b addr=%0d data=%h", i, imem_we, imem_addr, imem_wdata);
            end
        end
        n_checks++;
        if ({err, in_ready, core_req} !== 4'b0101) begin
            n_errors++;
            $display("FAIL ovf_launch got err=%b rdy=%b req=%b want 01 0 1", err, in_ready, core_req);
        end
        in_data = 9'h1EE;
        step();
        n_checks++;
        if ({imem_we, in_ready, busy} !== 3'b001) begin
            n_errors++;
            $display("FAIL ovf_nowrap got we=%b rdy=%b busy=%b want 0 0 1", imem_we, in_ready, busy);
        end
        in_valid  = 1'b0;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        n_checks++;
        if ({finished, err} !== 3'b101) begin
            n_errors++;
            $display("FAIL ovf_sticky got fin=%b err=%b want 1 01", finished, err);
        end
    endtask

    task automatic test_timeout();
        in_valid = 1'b1;
        in_data  = 9'h033;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if ({core_req, imem_we, imem_addr, err} !== {2'b11, 3'd0, 2'b00}) begin
            n_errors++;
            $display("FAIL single_word got req=%b we=%b addr=%0d err=%b want 1 1 0 00", core_req, imem_we, imem_addr, err);
        end
        step();
        repeat (15) step();
        n_checks++;
        if ({busy, cycles} !== {1'b1, 4'd15}) begin
            n_errors++;
            $display("FAIL to_count got busy=%b cyc=%0d want 1 15", busy, cycles);
        end
        repeat (3) step();
        n_checks++;
`ifdef PROG_LOADER_TIMEOUT_EN
        if ({finished, busy, err, cycles} !== {2'b10, 2'b10, 4'd15}) begin
            n_errors++;
            $display("FAIL timeout got fin=%b busy=%b err=%b cyc=%0d want 1 0 10 15", finished, busy, err, cycles);
        end
`else
        if ({finished, busy, err, cycles} !== {2'b01, 2'b00, 4'd15}) begin
            n_errors++;
            $display("FAIL saturate got fin=%b busy=%b err=%b cyc=%0d want 0 1 00 15", finished, busy, err, cycles);
        end
`endif
    endtask

    task automatic test_reset_in_run();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'h077;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({busy, cycles} !== {1'b1, 4'd2}) begin
            n_errors++;
            $display("FAIL pre_reset_run got busy=%b cyc=%0d want 1 2", busy, cycles);
        end
        reset     = 1'b1;
        core_done = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'h1AB;
        step();
        reset     = 1'b0;
        core_done = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if ({in_ready, core_reset, imem_we, core_req, busy, finished} !== 6'b110000) begin
            n_errors++;
            $display("FAIL run_reset_flags got %b want 110000", {in_ready, core_reset, imem_we, core_req, busy, finished});
        end
        n_checks++;
        if ({cycles, err, imem_addr, imem_wdata} !== '0) begin
            n_errors++;
            $display("FAIL run_reset_values got cyc=%0d err=%b addr=%0d data=%h want all 0", cycles, err, imem_addr, imem_wdata);
        end
        step();
        n_checks++;
        if ({imem_we, busy, core_reset} !== 3'b001) begin
            n_errors++;
            $display("FAIL post_reset_idle got we=%b busy=%b crst=%b want 0 0 1", imem_we, busy, core_reset);
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_gaps();
        test_overflow();
        test_timeout();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
